// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg
//   Shared definitions for the two-requester APB arbiter.
//   - arb_state_e : arbiter FSM state encoding
//   - REQ_M0/M1   : requester ids (also the encoding of the priority pointer)
//   - ADDR_W_DEF / DATA_W_DEF : default bus widths
package apb_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// apb_rr_pick
//   Combinational winner selection between two requesters.
//   Optional feature macro: APB_ARB_LOCK_EN (adds lock inputs and reports the
//   winner's lock bit so the top can hold priority).
//   Ports:
//     m0_req_i, m1_req_i   : level requests
//     ptr_i                : preferred requester when both request
//     m0_lock_i, m1_lock_i : lock flags (APB_ARB_LOCK_EN only)
//     win_lock_o           : lock flag of the winner (APB_ARB_LOCK_EN only)
//     any_o                : at least one request pending
//     win_o                : winning requester id
module apb_rr_pick
  import apb_arb_pkg::*;
(
  input  logic m0_req_i,
  input  logic m1_req_i,
  input  logic ptr_i,
`ifdef APB_ARB_LOCK_EN
  input  logic m0_lock_i,
  input  logic m1_lock_i,
  output logic win_lock_o,
`endif
  output logic any_o,
  output logic win_o
);

  always_comb begin
    any_o = m0_req_i | m1_req_i;
    if (m0_req_i && m1_req_i) begin
      win_o = ptr_i;
    end else if (m1_req_i) begin
      win_o = REQ_M1;
    end else begin
      win_o = REQ_M0;
    end
  end

`ifdef APB_ARB_LOCK_EN
  assign win_lock_o = (win_o == REQ_M1) ? m1_lock_i : m0_lock_i;
`endif

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Arbitrates two simple request/ready ports onto one APB master trigger
//   interface with round-robin priority.
//   Optional feature macro: APB_ARB_LOCK_EN (adds m0_lock/m1_lock; a locked
//   winner keeps priority for the following arbitration).
//   Ports:
//     PCLK, PRESET                 : clock, async active-high reset
//     mN_req/addr/wdata/write      : requester N transfer request
//     mN_lock                      : requester N lock (APB_ARB_LOCK_EN only)
//     mN_ready, mN_rdata           : requester N completion pulse and read data
//     mst_transfer                 : one-cycle trigger to the APB master
//     mst_addr/wdata/write         : latched transfer fields
//     mst_ready, mst_rdata         : master completion and read data
//     busy                         : arbiter not idle
//
//   state     | meaning
//   ARB_IDLE  | sample requests, latch winner and its fields
//   ARB_ISSUE | pulse mst_transfer
//   ARB_WAIT  | wait for mst_ready, capture mst_rdata
//   ARB_DONE  | pulse winner's ready, update priority pointer
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_write,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_write,
`ifdef APB_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mst_transfer,
  output logic [ADDR_W-1:0] mst_addr,
  output logic [DATA_W-1:0] mst_wdata,
  output logic              mst_write,
  input  logic              mst_ready,
  input  logic [DATA_W-1:0] mst_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              win_q, win_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              lock_q, lock_d;

  logic              pick_any;
  logic              pick_win;
  logic              pick_lock;

`ifdef APB_ARB_LOCK_EN
  apb_rr_pick u_pick (
    .m0_req_i   (m0_req),
    .m1_req_i   (m1_req),
    .ptr_i      (ptr_q),
    .m0_lock_i  (m0_lock),
    .m1_lock_i  (m1_lock),
    .win_lock_o (pick_lock),
    .any_o      (pick_any),
    .win_o      (pick_win)
  );
`else
  apb_rr_pick u_pick (
    .m0_req_i (m0_req),
    .m1_req_i (m1_req),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .win_o    (pick_win)
  );
  assign pick_lock = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    lock_d     = lock_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_ISSUE;
          win_d   = pick_win;
          lock_d  = pick_lock;
          addr_d  = (pick_win == REQ_M1) ? m1_addr  : m0_addr;
          wdata_d = (pick_win == REQ_M1) ? m1_wdata : m0_wdata;
          write_d = (pick_win == REQ_M1) ? m1_write : m0_write;
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (mst_ready) begin
          state_d = ARB_DONE;
          if (win_q == REQ_M1) begin
            m1_rdata_d = mst_rdata;
          end else begin
            m0_rdata_d = mst_rdata;
          end
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
        // A locked winner keeps the pointer so its follow-up access wins;
        // an unlocked win hands priority to the other requester.
        ptr_d   = lock_q ? win_q : ~win_q;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= REQ_M0;
      win_q      <= REQ_M0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      lock_q     <= lock_d;
    end
  end

  assign mst_transfer = (state_q == ARB_ISSUE);
  assign busy         = (state_q != ARB_IDLE);
  assign m0_ready     = (state_q == ARB_DONE) && (win_q == REQ_M0);
  assign m1_ready     = (state_q == ARB_DONE) && (win_q == REQ_M1);
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;
  assign mst_addr     = addr_q;
  assign mst_wdata    = wdata_q;
  assign mst_write    = write_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized scoreboard bench for apb_req_arbiter. The sequencer raises
// requests in the idle cycle and predicts the grant from the arbitration
// rules; a master responder and a ready monitor check independently.
module tb_apb_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_write = 1'b0, m1_write = 1'b0;
`ifdef APB_ARB_LOCK_EN
  logic          m0_lock = 1'b0, m1_lock = 1'b0;
`endif
  logic          m0_ready, m1_ready;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mst_transfer;
  logic [AW-1:0] mst_addr;
  logic [DW-1:0] mst_wdata;
  logic          mst_write;
  logic          mst_ready = 1'b0;
  logic [DW-1:0] mst_rdata = '0;
  logic          busy;

  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .m0_req       (m0_req),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_write     (m0_write),
    .m1_req       (m1_req),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_write     (m1_write),
`ifdef APB_ARB_LOCK_EN
    .m0_lock      (m0_lock),
    .m1_lock      (m1_lock),
`endif
    .m0_ready     (m0_ready),
    .m0_rdata     (m0_rdata),
    .m1_ready     (m1_ready),
    .m1_rdata     (m1_rdata),
    .mst_transfer (mst_transfer),
    .mst_addr     (mst_addr),
    .mst_wdata    (mst_wdata),
    .mst_write    (mst_write),
    .mst_ready    (mst_ready),
    .mst_rdata    (mst_rdata),
    .busy         (busy)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        lock;
  } req_t;

  typedef struct {
    int id;
    int arb_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    int          w;
  } rsp_t;

  exp_t        exp_q[$];
  req_t        mst_q[$];
  rsp_t        rsp_q[$];
  req_t        preq[2];
  bit          pend[2];
  int          mptr = 0;
  logic [31:0] last_rd[2];

  bit          rsp_off = 1'b0;
  int          fix_wait = -1;
  bit          fix_rd_en = 1'b0;
  logic [31:0] fix_rd = '0;

  function automatic logic rdy(input int id);
    return (id == 1) ? m1_ready : m0_ready;
  endfunction

  task automatic drive(input int id, input req_t r, input logic rq);
    if (id == 0) begin
      m0_req = rq; m0_addr = r.addr; m0_wdata = r.wdata; m0_write = r.wr;
`ifdef APB_ARB_LOCK_EN
      m0_lock = r.lock;
`endif
    end else begin
      m1_req = rq; m1_addr = r.addr; m1_wdata = r.wdata; m1_write = r.wr;
`ifdef APB_ARB_LOCK_EN
      m1_lock = r.lock;
`endif
    end
  endtask

  task automatic raise(input int id, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic lk);
    req_t r;
    r.addr = a; r.wdata = d; r.wr = w; r.lock = lk;
    preq[id] = r;
    pend[id] = 1'b1;
    drive(id, r, 1'b1);
  endtask

  // Called in an idle cycle (just after a rising edge) with requests set up.
  task automatic serve();
    int   win;
    bit   got;
    req_t s;
    exp_t e;
    if (pend[0] && pend[1]) win = mptr;
    else                    win = pend[1] ? 1 : 0;
    e.id = win; e.arb_cyc = cyc;
    exp_q.push_back(e);
    mst_q.push_back(preq[win]);
`ifdef APB_ARB_LOCK_EN
    mptr = preq[win].lock ? win : 1 - win;
`else
    mptr = 1 - win;
`endif
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge PCLK); #1;
      if (rdy(win)) begin
        got = 1'b1;
        break;
      end
      // The latched transfer must ignore requester field changes.
      s = preq[win];
      s.addr = $urandom; s.wdata = $urandom; s.wr = 1'($urandom % 2);
      drive(win, s, 1'b1);
    end
    chk("ready_within_bound", got, 1);
    @(posedge PCLK); #1;
    pend[win] = 1'b0;
    drive(win, preq[win], 1'b0);
  endtask

  task automatic do_reset();
    req_t z;
    z.addr = '0; z.wdata = '0; z.wr = 1'b0; z.lock = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b1;
    drive(0, z, 1'b0);
    drive(1, z, 1'b0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    mptr = 0;
    last_rd[0] = '0; last_rd[1] = '0;
    @(posedge PCLK); #1;
  endtask

  // Master responder.
  req_t rsp_e;
  rsp_t rsp_r;
  initial begin
    forever begin
      @(negedge PCLK);
      if (mst_transfer && !rsp_off && !PRESET) begin
        chk("transfer_expected", mst_q.size() != 0, 1);
        if (mst_q.size() != 0) begin
          rsp_e = mst_q.pop_front();
          chk("mst_addr", mst_addr, rsp_e.addr);
          chk("mst_wdata", mst_wdata, rsp_e.wdata);
          chk("mst_write", mst_write, rsp_e.wr);
          rsp_r.w     = (fix_wait >= 0) ? fix_wait : int'($urandom_range(0, 3));
          rsp_r.rdata = fix_rd_en ? fix_rd : $urandom;
          rsp_q.push_back(rsp_r);
          @(posedge PCLK); #1;
          chk("transfer_one_cycle", mst_transfer, 0);
          repeat (rsp_r.w) begin
            @(posedge PCLK); #1;
          end
          mst_ready = 1'b1;
          mst_rdata = rsp_r.rdata;
          chk("mst_addr_hold", mst_addr, rsp_e.addr);
          chk("mst_wdata_hold", mst_wdata, rsp_e.wdata);
          @(posedge PCLK); #1;
          mst_ready = 1'b0;
          mst_rdata = $urandom;
        end
      end
    end
  end

  // Ready monitor / scoreboard.
  exp_t mon_e;
  rsp_t mon_r;
  initial begin
    forever begin
      @(negedge PCLK);
      if (!PRESET && (m0_ready || m1_ready)) begin
        chk("ready_onehot", m0_ready && m1_ready, 0);
        chk("ready_expected", (exp_q.size() != 0) && (rsp_q.size() != 0), 1);
        if (exp_q.size() != 0 && rsp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          mon_r = rsp_q.pop_front();
          chk("grant_winner_ready", rdy(mon_e.id), 1);
          chk("grant_other_ready", rdy(1 - mon_e.id), 0);
          chk("latency", cyc, mon_e.arb_cyc + 3 + mon_r.w);
          last_rd[mon_e.id] = mon_r.rdata;
          chk("rdata_winner", (mon_e.id == 1) ? m1_rdata : m0_rdata, mon_r.rdata);
          chk("rdata_other_hold", (mon_e.id == 1) ? m0_rdata : m1_rdata, last_rd[1 - mon_e.id]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    logic lk;
    last_rd[0] = '0; last_rd[1] = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;

    // Reset state.
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_transfer", mst_transfer, 0);
    chk("rst_m0_ready", m0_ready, 0);
    chk("rst_m1_ready", m1_ready, 0);
    chk("rst_mst_write", mst_write, 0);
    chk("rst_mst_addr", mst_addr, 0);
    chk("rst_mst_wdata", mst_wdata, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Single write from m0, master answers immediately.
    fix_wait = 0;
    raise(0, 32'h1000_1004, 32'h0000_00A5, 1'b1, 1'b0);
    serve();

    // Read from m1 with three master wait cycles.
    fix_wait = 3; fix_rd_en = 1'b1; fix_rd = 32'h1234_5678;
    raise(1, 32'h2000_0000, 32'h0, 1'b0, 1'b0);
    serve();
    chk("m1_rdata_read", m1_rdata, 32'h1234_5678);
    fix_rd_en = 1'b0;

    // Address change during the wait phase must not reach the master.
    fix_wait = 2;
    raise(0, 32'h1000_0000, 32'h5A5A_0001, 1'b1, 1'b0);
    serve();
    fix_wait = -1;

    // Reset during ARB_WAIT aborts without a ready pulse.
    rsp_off = 1'b1;
    r.addr = 32'h3000_0000; r.wdata = 32'h1; r.wr = 1'b1; r.lock = 1'b0;
    drive(0, r, 1'b1);
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("abort_busy_before", busy, 1);
    PRESET = 1'b1;
    #2;
    chk("abort_busy", busy, 0);
    chk("abort_m0_ready", m0_ready, 0);
    chk("abort_transfer", mst_transfer, 0);
    chk("abort_m1_rdata_clr", m1_rdata, 0);
    drive(0, r, 1'b0);
    @(negedge PCLK);
    PRESET = 1'b0;
    rsp_off = 1'b0;
    mptr = 0;
    last_rd[0] = '0; last_rd[1] = '0;
    @(posedge PCLK); #1;
    raise(0, 32'h3000_0004, 32'h2, 1'b0, 1'b0);
    serve();

    // Contention from reset: alternating grants, back-to-back.
    do_reset();
    raise(0, 32'h1000_0010, 32'h10, 1'b1, 1'b0);
    raise(1, 32'h2000_0010, 32'h20, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      serve();
      for (int id = 0; id < 2; id++)
        if (!pend[id]) raise(id, $urandom, $urandom, 1'($urandom % 2), 1'b0);
    end
    while (pend[0] || pend[1]) serve();

`ifdef APB_ARB_LOCK_EN
    // Locked read-modify-write by m0 while m1 keeps requesting.
    do_reset();
    raise(0, 32'h1000_2000, 32'h0, 1'b0, 1'b1);
    raise(1, 32'h2000_2000, 32'h77, 1'b1, 1'b0);
    serve();
    raise(0, 32'h1000_2000, 32'hBEEF_0001, 1'b1, 1'b0);
    serve();
    serve();
`endif

    // Randomized traffic.
    repeat (60) begin
      for (int id = 0; id < 2; id++) begin
        if (!pend[id] && $urandom_range(0, 2) != 0) begin
`ifdef APB_ARB_LOCK_EN
          lk = 1'($urandom % 2);
`else
          lk = 1'b0;
`endif
          raise(id, $urandom, $urandom, 1'($urandom % 2), lk);
        end
      end
      if (!pend[0] && !pend[1]) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge PCLK); #1;
        end
        raise(int'($urandom % 2), $urandom, $urandom, 1'($urandom % 2), 1'b0);
      end
      serve();
    end
    while (pend[0] || pend[1]) serve();

    repeat (5) @(posedge PCLK);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("mst_q_drained", mst_q.size(), 0);
    chk("idle_at_end", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
